// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the pipelined multiply cell (mul_cell_pipe).
//
// Contents:
//   MUL_LAT_BASE   : enabled edges from in_valid to out_valid without the
//                    optional output register.
//   MUL_MAX_W      : widest operand the shared types can carry. The top
//                    zero-extends narrower operands into these containers.
//   mul_word_t     : MUL_MAX_W-bit container for operands and partial products.
//   mul_s1_t       : stage-1 view of one operation (four partial products,
//                    sign flags, raw operands, word select, valid).
//   mul_sign_corr  : high-word correction term for two's-complement operands.
// -----------------------------------------------------------------------------
package mul_pkg;

    localparam int MUL_LAT_BASE = 2;
    localparam int MUL_MAX_W    = 64;

    typedef logic [MUL_MAX_W-1:0] mul_word_t;

    typedef struct packed {
        mul_word_t p_ll;    // aL * bL
        mul_word_t p_lh;    // aL * bH
        mul_word_t p_hl;    // aH * bL
        mul_word_t p_hh;    // aH * bH
        logic      a_neg;   // A is negative and treated as signed
        logic      b_neg;   // B is negative and treated as signed
        mul_word_t src1;
        mul_word_t src2;
        logic      sel_hi;
        logic      v;
    } mul_s1_t;

    // A signed operand X equals its unsigned bit pattern minus 2^W when its
    // msb is set. Expanding (A - a_neg*2^W)(B - b_neg*2^W) modulo 2^(2W) leaves
    // the unsigned product minus (a_neg*B + b_neg*A) << W; the a_neg*b_neg
    // term falls off the top. This returns the sum to subtract from the high
    // word; the caller truncates it to its own width.
    function automatic mul_word_t mul_sign_corr(
        input logic      a_neg,
        input logic      b_neg,
        input mul_word_t src1,
        input mul_word_t src2
    );
        mul_word_t corr;
        corr = '0;
        if (a_neg) corr = corr + src2;
        if (b_neg) corr = corr + src1;
        return corr;
    endfunction

endpackage

// File: rtl/mul_cell_pipe_if.sv
// -----------------------------------------------------------------------------
// mul_cell_pipe_if
// Operand/result bundle between the execute stage and the multiply cell.
//
// Signals:
//   en        pipeline advance (0 freezes every stage register)
//   flush     invalidate all in-flight operations
//   in_valid  operands present this cycle
//   src1/src2 operands A and B (DATA_W bits)
//   sign_a/b  treat the matching operand as two's complement
//   sel_hi    1 = high product word, 0 = low product word
//   out_valid result valid
//   result    selected product word (DATA_W bits)
//   busy      at least one stage holds a valid operation
//
// Modports:
//   master : the execute stage (drives operands/control, reads results)
//   slave  : the multiply cell
// -----------------------------------------------------------------------------
interface mul_cell_pipe_if #(
    parameter int DATA_W = 32
);

    logic              en;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic              sign_a;
    logic              sign_b;
    logic              sel_hi;
    logic              out_valid;
    logic [DATA_W-1:0] result;
    logic              busy;

    modport master (
        output en, flush, in_valid, src1, src2, sign_a, sign_b, sel_hi,
        input  out_valid, result, busy
    );

    modport slave (
        input  en, flush, in_valid, src1, src2, sign_a, sign_b, sel_hi,
        output out_valid, result, busy
    );

endinterface

// File: rtl/mul_pp16.sv
// -----------------------------------------------------------------------------
// mul_pp16
// Registered unsigned HALF_W x HALF_W multiplier; one DSP-style slice of the
// multiply cell. The product register is the partial-product half of stage 1.
//
// Ports:
//   clk      clock
//   reset_n  synchronous active-low reset (clears the product register)
//   en       capture enable; 0 holds the product
//   a, b     unsigned HALF_W-bit factors
//   p        registered 2*HALF_W-bit product
// -----------------------------------------------------------------------------
module mul_pp16 #(
    parameter int HALF_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [HALF_W-1:0]   a,
    input  logic [HALF_W-1:0]   b,
    output logic [2*HALF_W-1:0] p
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p <= '0;
        end else if (en) begin
            // Widen both factors first so the product is sized to the full
            // 2*HALF_W result rather than relying on context sizing.
            p <= {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};
        end
    end

endmodule

// File: rtl/mul_cell_pipe.sv
// -----------------------------------------------------------------------------
// mul_cell_pipe
// Pipelined DATA_W x DATA_W multiply cell serving MUL, MULXSS, MULXSU and
// MULXUU. The full 2*DATA_W product is built from four unsigned half-width
// partial products, corrected for signed operands, and the low or high word
// is returned.
//
// Pipeline:
//   S1  four registered partial products (mul_pp16 x4) plus sign flags,
//       operands, word select and v1.
//   S2  unsigned sum, sign correction, word select -> result register, v2.
//   S3  optional output register (v3), present when MUL_OUT_REG_EN is defined.
//
// Configuration macro:
//   MUL_OUT_REG_EN  defined   : 3 enabled edges of latency, busy = v1|v2|v3
//                   undefined : 2 enabled edges of latency, busy = v1|v2
//
// Ports:
//   clk      clock
//   reset_n  synchronous active-low reset; overrides en and flush
//   bus      mul_cell_pipe_if.slave (en, flush, operands, result, busy)
// -----------------------------------------------------------------------------
module mul_cell_pipe
    import mul_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    mul_cell_pipe_if.slave  bus
);

    localparam int HALF_W = DATA_W / 2;
    localparam int PROD_W = 2 * DATA_W;

    if ((DATA_W < 8) || ((DATA_W % 2) != 0) || (DATA_W > MUL_MAX_W)) begin : g_bad_width
        $error("mul_cell_pipe: DATA_W must be even, >= 8 and <= MUL_MAX_W");
    end

    // ------------------------------------------------------------------
    // Stage 1: partial products
    // ------------------------------------------------------------------
    logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;

    assign a_lo = bus.src1[HALF_W-1:0];
    assign a_hi = bus.src1[DATA_W-1:HALF_W];
    assign b_lo = bus.src2[HALF_W-1:0];
    assign b_hi = bus.src2[DATA_W-1:HALF_W];

    logic [DATA_W-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

    mul_pp16 #(.HALF_W(HALF_W)) u_pp_ll (
        .clk(clk), .reset_n(reset_n), .en(bus.en), .a(a_lo), .b(b_lo), .p(pp_ll)
    );
    mul_pp16 #(.HALF_W(HALF_W)) u_pp_lh (
        .clk(clk), .reset_n(reset_n), .en(bus.en), .a(a_lo), .b(b_hi), .p(pp_lh)
    );
    mul_pp16 #(.HALF_W(HALF_W)) u_pp_hl (
        .clk(clk), .reset_n(reset_n), .en(bus.en), .a(a_hi), .b(b_lo), .p(pp_hl)
    );
    mul_pp16 #(.HALF_W(HALF_W)) u_pp_hh (
        .clk(clk), .reset_n(reset_n), .en(bus.en), .a(a_hi), .b(b_hi), .p(pp_hh)
    );

    // ------------------------------------------------------------------
    // Stage 1: side-band registers travelling with the partial products
    // ------------------------------------------------------------------
    logic              a_neg_q;
    logic              b_neg_q;
    logic              sel_hi_q;
    logic              v1_q;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;

    // NOTE: state is written with <= so every register samples the values
    // from before the edge; = here would let later statements see new values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: data registers are reset along with the valid bits so
            // result reads 0 after reset instead of stale operands.
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            sel_hi_q <= 1'b0;
            v1_q     <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
        end else begin
            if (bus.en) begin
                a_neg_q  <= bus.sign_a & bus.src1[DATA_W-1];
                b_neg_q  <= bus.sign_b & bus.src2[DATA_W-1];
                sel_hi_q <= bus.sel_hi;
                v1_q     <= bus.in_valid;
                src1_q   <= bus.src1;
                src2_q   <= bus.src2;
            end
            // NOTE: the later non-blocking write wins, so flush clears v1 even
            // when en also captured a new in_valid this edge.
            if (bus.flush) begin
                v1_q <= 1'b0;
            end
        end
    end

    // Stage-1 view assembled from the slice registers and side-band registers.
    mul_s1_t s1;

    // NOTE: s1 is fully assigned first so no field can hold a previous value
    // and infer a latch.
    always_comb begin
        s1        = '0;
        s1.p_ll   = mul_word_t'(pp_ll);
        s1.p_lh   = mul_word_t'(pp_lh);
        s1.p_hl   = mul_word_t'(pp_hl);
        s1.p_hh   = mul_word_t'(pp_hh);
        s1.a_neg  = a_neg_q;
        s1.b_neg  = b_neg_q;
        s1.src1   = mul_word_t'(src1_q);
        s1.src2   = mul_word_t'(src2_q);
        s1.sel_hi = sel_hi_q;
        s1.v      = v1_q;
    end

    // ------------------------------------------------------------------
    // Stage 2: recombine, correct for sign, select word
    // ------------------------------------------------------------------
    logic [PROD_W-1:0] prod_u;
    logic [DATA_W-1:0] corr;
    logic [PROD_W-1:0] prod;
    logic [DATA_W-1:0] word_sel;

    always_comb begin
        prod_u = PROD_W'(s1.p_ll)
               + (PROD_W'(s1.p_lh) << HALF_W)
               + (PROD_W'(s1.p_hl) << HALF_W)
               + (PROD_W'(s1.p_hh) << DATA_W);
        // Correction only touches the high word, so a DATA_W-bit term
        // shifted up by DATA_W is exact modulo 2^PROD_W.
        corr     = DATA_W'(mul_sign_corr(s1.a_neg, s1.b_neg, s1.src1, s1.src2));
        prod     = prod_u - {corr, {DATA_W{1'b0}}};
        word_sel = s1.sel_hi ? prod[PROD_W-1:DATA_W] : prod[DATA_W-1:0];
    end

    logic [DATA_W-1:0] res2_q;
    logic              v2_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            res2_q <= '0;
            v2_q   <= 1'b0;
        end else begin
            if (bus.en) begin
                res2_q <= word_sel;
                v2_q   <= s1.v;
            end
            if (bus.flush) begin
                v2_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional stage 3 and outputs
    // ------------------------------------------------------------------
`ifdef MUL_OUT_REG_EN
    logic [DATA_W-1:0] res3_q;
    logic              v3_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            res3_q <= '0;
            v3_q   <= 1'b0;
        end else begin
            if (bus.en) begin
                res3_q <= res2_q;
                v3_q   <= v2_q;
            end
            if (bus.flush) begin
                v3_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = v3_q;
    assign bus.result    = res3_q;
    assign bus.busy      = v1_q | v2_q | v3_q;
`else
    assign bus.out_valid = v2_q;
    assign bus.result    = res2_q;
    assign bus.busy      = v1_q | v2_q;
`endif

endmodule

// File: tb/tb_mul_cell_pipe.sv
// -----------------------------------------------------------------------------
// tb_mul_cell_pipe
// Self-checking bench for mul_cell_pipe (DATA_W = 32). A reference model keeps
// the expected product of each in-flight operation (computed with plain 64-bit
// arithmetic on sign-extended operands) in a latency-deep queue that follows
// en, flush and reset_n. DUT outputs are compared on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mul_cell_pipe;

    localparam int DATA_W = 32;
`ifdef MUL_OUT_REG_EN
    localparam int LAT = mul_pkg::MUL_LAT_BASE + 1;
`else
    localparam int LAT = mul_pkg::MUL_LAT_BASE;
`endif

    logic clk;
    logic reset_n;

    mul_cell_pipe_if #(.DATA_W(DATA_W)) bus ();

    mul_cell_pipe #(.DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard counters and checking task
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [31:0] ref_word(
        input logic [31:0] a, input logic [31:0] b,
        input logic sa, input logic sb, input logic hi
    );
        logic [63:0] ax, bx, p;
        ax = sa ? {{32{a[31]}}, a} : {32'h0, a};
        bx = sb ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ax * bx;
        return hi ? p[63:32] : p[31:0];
    endfunction

    bit          mv [LAT];
    logic [31:0] mr [LAT];
    bit          res_zero = 1'b0;
    bit          en_edge  = 1'b0;

    initial begin
        for (int i = 0; i < LAT; i++) begin
            mv[i] = 1'b0;
            mr[i] = '0;
        end
    end

    always @(posedge clk) begin
        en_edge = 1'b0;
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) mv[i] = 1'b0;
            res_zero = 1'b1;
        end else begin
            if (bus.en) begin
                en_edge = 1'b1;
                for (int i = LAT - 1; i > 0; i--) begin
                    mv[i] = mv[i-1];
                    mr[i] = mr[i-1];
                end
                mv[0] = bus.in_valid;
                mr[0] = ref_word(bus.src1, bus.src2, bus.sign_a, bus.sign_b, bus.sel_hi);
                res_zero = 1'b0;
            end
            if (bus.flush) begin
                for (int i = 0; i < LAT; i++) mv[i] = 1'b0;
            end
        end
    end

    function automatic logic model_busy();
        logic b;
        b = 1'b0;
        for (int i = 0; i < LAT; i++) b = b | mv[i];
        return b;
    endfunction

    // Results seen on edges that actually advanced the pipeline.
    logic [31:0] got_q[$];

    // Advance one clock and compare every output against the model.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check("out_valid", 32'(bus.out_valid), 32'(mv[LAT-1]));
        check("busy", 32'(bus.busy), 32'(model_busy()));
        if (mv[LAT-1]) begin
            check("result", bus.result, mr[LAT-1]);
        end else if (res_zero) begin
            check("result_rst", bus.result, 32'h0);
        end
        if (bus.out_valid && en_edge) got_q.push_back(bus.result);
    endtask

    task automatic drive(
        input logic en, input logic flush, input logic vld,
        input logic [31:0] a, input logic [31:0] b,
        input logic sa, input logic sb, input logic hi
    );
        bus.en       = en;
        bus.flush    = flush;
        bus.in_valid = vld;
        bus.src1     = a;
        bus.src2     = b;
        bus.sign_a   = sa;
        bus.sign_b   = sb;
        bus.sel_hi   = hi;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Issue one operation, run bubbles behind it and check the known answer.
    task automatic run_op(
        input string tag, input logic [31:0] a, input logic [31:0] b,
        input logic sa, input logic sb, input logic hi, input logic [31:0] exp
    );
        drive(1'b1, 1'b0, 1'b1, a, b, sa, sb, hi);
        tick();
        idle();
        for (int i = 1; i < LAT; i++) tick();
        check({tag, "_valid"}, 32'(bus.out_valid), 32'h1);
        check(tag, bus.result, exp);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset_n = 1'b0;
        idle();
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_result", bus.result, 32'h0);
        reset_n = 1'b1;

        // Known-answer operations across the signedness and word-select space.
        run_op("uu_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0000_0001);
        run_op("uu_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        run_op("ss_hi", 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        run_op("ss_lo", 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE);
        run_op("su_hi", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h8000_0000);
        run_op("ss_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 32'h4000_0000);

        // Back-to-back with a two-cycle stall after the second operation.
        got_q.delete();
        drive(1'b1, 1'b0, 1'b1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'd7, 32'd8, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'd7, 32'd8, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        for (int i = 0; i < LAT + 1; i++) tick();
        check("stall_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("stall_r0", got_q[0], 32'd12);
            check("stall_r1", got_q[1], 32'd30);
            check("stall_r2", got_q[2], 32'd56);
        end

        // Flush with two operations in flight; a third arrives with the flush.
        drive(1'b1, 1'b0, 1'b1, 32'd11, 32'd12, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'd13, 32'd14, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'd15, 32'd16, 1'b0, 1'b0, 1'b0);
        tick();
        check("flush_out_valid", 32'(bus.out_valid), 32'h0);
        check("flush_busy", 32'(bus.busy), 32'h0);
        idle();
        for (int i = 0; i < LAT; i++) tick();
        check("flush_dropped", 32'(bus.busy), 32'h0);
        run_op("post_flush", 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 32'd81);

        // Reset with both stages holding valid operations.
        drive(1'b1, 1'b0, 1'b1, 32'd21, 32'd22, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'd23, 32'd24, 1'b0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'd25, 32'd26, 1'b0, 1'b0, 1'b0);
        tick();
        check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        check("midrst_result", bus.result, 32'h0);
        reset_n = 1'b1;
        run_op("post_rst", 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 32'd700);

        // Randomized traffic: stalls, rare flushes and rare resets.
        for (int n = 0; n < 600; n++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 3) != 0), pick_operand(), pick_operand(),
                  1'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        reset_n = 1'b1;
        idle();
        for (int i = 0; i < LAT + 1; i++) tick();
        check("drain_busy", 32'(bus.busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_cell_pipe.md
Name: mul_cell_pipe

Overview:
- Parametrised successor to the CPU 3-partial-product multiply cell.
- Forms the full 2*DATA_W product from all four half-width partial products, with per-operand signedness. Selects the low or high word of the product, so MUL, MULXSS, MULXSU and MULXUU are all served by one unit.
- Sits between the execute stage (operands) and the writeback mux (result).
- Has a valid-tagged 2-stage pipeline with stall (enable) and flush.

Parameters:
- DATA_W, 32, operand width; must be even and at least 8.
- HALF_W, DATA_W/2, partial-product slice width; derived, not overridable.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- en  in  1  pipeline advance; 0 freezes all stage registers
- flush  in  1  invalidates all in-flight operations
- in_valid  in  1  operands present this cycle
- src1  in  DATA_W  operand A
- src2  in  DATA_W  operand B
- sign_a  in  1  treat A as two's complement
- sign_b  in  1  treat B as two's complement
- sel_hi  in  1  1 = return product[2*DATA_W-1:DATA_W]; 0 = return product[DATA_W-1:0]
- out_valid  out  1  result valid
- result  out  DATA_W  selected product word
- busy  out  1  at least one stage holds a valid operation

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset: on a clk edge with reset_n=0, clear all valid bits and data registers. Outputs read out_valid=0, result=0, busy=0 from the following cycle. Reset overrides en and flush.
- Stage 1 (S1), captured when en=1:
  - Registers the four unsigned HALF_W x HALF_W products: pLL=aL*bL, pLH=aL*bH, pHL=aH*bL, pHH=aH*bH.
  - Also registers sign_a&A[msb], sign_b&B[msb], sel_hi, the A and B operands (for correction) and v1=in_valid.
- Stage 2 (S2), captured when en=1:
  - U = pLL + (pLH<<HALF_W) + (pHL<<HALF_W) + (pHH<<DATA_W), computed modulo 2^(2*DATA_W).
  - If A is negative under sign_a, subtract B<<DATA_W. If B is negative under sign_b, subtract A<<DATA_W. Both subtractions are modulo 2^(2*DATA_W).
  - The result register takes the word selected by sel_hi; v2=v1.
- Outputs:
  - out_valid=v2.
  - result is the S2 register, held until the next en=1 edge.
  - busy=v1|v2.
- Latency: exactly 2 en=1 edges from in_valid to out_valid. Throughput is one operation per enabled cycle.
- en=0: every register holds, including valid bits; out_valid stays asserted if set.
- flush=1 (with reset_n=1): on the edge, v1 and v2 are cleared regardless of en, and data registers are untouched. If in_valid=1 in the same cycle, that operation is also dropped.
- in_valid=0 with en=1: a bubble propagates. Data registers may update; result is don't-care while out_valid=0.
- Overflow is impossible: the full 2*DATA_W product is exact for every signedness combination.

Optional Feature:
- MUL_OUT_REG_EN defined:
  - Adds a third register stage (S3) after S2, gated by en and cleared by flush and reset.
  - Latency becomes 3 enabled edges; busy=v1|v2|v3.
- Undefined: 2-stage behaviour as above.

Decomposition:
- Shared package mul_pkg holds:
  - the constant MUL_LAT_BASE=2;
  - a packed struct mul_s1_t {pLL, pLH, pHL, pHH, a_neg, b_neg, src1, src2, sel_hi, v};
  - a function for the signed-correction term.
- One natural sub-module: mul_pp16, a registered unsigned HALF_W x HALF_W multiplier instantiated four times, mapping to a DSP block.

Test Plan (DATA_W=32):
- Unsigned low: src1=0xFFFFFFFF, src2=0xFFFFFFFF, sign_a=sign_b=0, sel_hi=0, en=1 -> 2 cycles later result=0x00000001, out_valid=1. Same with sel_hi=1 -> 0xFFFFFFFE.
- Signed high: src1=0xFFFFFFFF (-1), src2=0x00000002, sign_a=sign_b=1, sel_hi=1 -> result=0xFFFFFFFF; sel_hi=0 -> 0xFFFFFFFE.
- Mixed signedness: src1=0x80000000, src2=0xFFFFFFFF, sign_a=1, sign_b=0, sel_hi=1 -> result=0x80000000 (-2^31*(2^32-1) high word).
- Back-to-back plus stall:
  - Stimulus: three operations on consecutive cycles (3*4, 5*6, 7*8, sel_hi=0), with en=0 for 2 cycles after the second.
  - Expected: results 12, 30, 56 in order; out_valid held during the stall, with no duplicate or lost operation.
- Flush: with two valid operations in flight, assert flush for 1 cycle -> out_valid=0 and busy=0 next cycle. A new operation 9*9 issued afterwards -> result=81 after 2 cycles.
- Reset mid-operation: reset_n=0 for 1 cycle with v1=v2=1 -> out_valid=0, result=0, busy=0 next cycle. The pipeline accepts a new operation the cycle after reset_n returns to 1.
